// File: rtl/ifu_fetch_stage.sv
// ifu_fetch_stage: instruction-fetch stage for the pipelined MIPS core.
//
// Holds the fetch PC and drives it to the instruction memory. The returned word is latched
// into the IF/ID register. The next PC is chosen from the instruction held in D:
// sequential, taken branch, j/jal or jr. The stage also handles stall, squashing the fetch
// after a redirect, and flagging fetches from a bad address.
//
// Optional feature macro: IFU_DELAY_SLOT_EN
//   defined   - MIPS delay slot: the instruction fetched alongside a redirect is kept.
//   undefined - the IF/ID load that accompanies a redirect is squashed (one bubble).
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   stall          in   hold PC and IF/ID
//   npc_sel[1:0]   in   D-stage next-PC select: 00 PC+4, 01 branch, 10 j/jal, 11 jr
//   branch_taken   in   branch comparison result for the D-stage instruction
//   imm16_D[15:0]  in   D-stage branch offset
//   instr_index_D  in   D-stage 26-bit jump index
//   rs_val_D[31:0] in   forwarded rs value for jr
//   ins_F[31:0]    in   instruction word at pc_F (combinational memory read)
//   pc_F[31:0]     out  fetch address
//   ins_D[31:0]    out  IF/ID instruction
//   pc_D[31:0]     out  IF/ID PC
//   pc8_D[31:0]    out  pc_D + 8, the jal link value
//   valid_D        out  IF/ID holds a real instruction
//   fetch_fault_D  out  IF/ID instruction came from a misaligned or out-of-window address

module ifu_fetch_stage #(
  parameter logic [31:0] PC_RESET       = 32'h0000_3000,
  parameter int unsigned IM_DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] imm16_D,
  input  logic [25:0] instr_index_D,
  input  logic [31:0] rs_val_D,
  input  logic [31:0] ins_F,
  output logic [31:0] pc_F,
  output logic [31:0] ins_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        valid_D,
  output logic        fetch_fault_D
);

  // Last legal word address. It is computed in 33 bits so that a window touching the top
  // of the address space does not wrap.
  localparam logic [32:0] WinFirst = {1'b0, PC_RESET};
  localparam logic [32:0] WinLast  = WinFirst + (33'(IM_DEPTH_WORDS) * 33'd4) - 33'd4;

  typedef enum logic [1:0] {
    NpcSeq    = 2'b00,
    NpcBranch = 2'b01,
    NpcJump   = 2'b10,
    NpcJr     = 2'b11
  } npc_sel_e;

  // State
  logic [31:0] pc_f_q;
  logic [31:0] ins_d_q;
  logic [31:0] pc_d_q;
  logic [31:0] pc8_d_q;
  logic        valid_d_q;
  logic        fault_d_q;

  // Next-PC datapath
  logic [31:0] pc_f_plus4;
  logic [31:0] pc_f_plus8;
  logic [31:0] pc_d_plus4;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic        wants_redirect;
  logic        redirect;
  logic [31:0] npc;

  // Fault detection and IF/ID load values
  logic        misaligned;
  logic        below_window;
  logic        above_window;
  logic        fetch_fault;
  logic        squash;
  logic [31:0] ins_load;
  logic        valid_load;
  logic        fault_load;

  always_comb begin
    pc_f_plus4    = pc_f_q + 32'd4;
    pc_f_plus8    = pc_f_q + 32'd8;
    pc_d_plus4    = pc_d_q + 32'd4;
    branch_off    = {{14{imm16_D[15]}}, imm16_D, 2'b00};
    branch_target = pc_d_plus4 + branch_off;
    jump_target   = {pc_d_plus4[31:28], instr_index_D, 2'b00};
  end

  // Target selection. A not-taken branch falls through to PC+4 like a plain instruction.
  always_comb begin
    wants_redirect = 1'b0;
    target         = pc_f_plus4;
    unique case (npc_sel_e'(npc_sel))
      NpcSeq: begin
        wants_redirect = 1'b0;
        target         = pc_f_plus4;
      end
      NpcBranch: begin
        wants_redirect = branch_taken;
        target         = branch_target;
      end
      NpcJump: begin
        wants_redirect = 1'b1;
        target         = jump_target;
      end
      NpcJr: begin
        wants_redirect = 1'b1;
        target         = rs_val_D;
      end
      default: begin
        wants_redirect = 1'b0;
        target         = pc_f_plus4;
      end
    endcase
  end

  // A bubble in D carries no control information, so npc_sel is ignored there.
  always_comb begin
    redirect = valid_d_q & wants_redirect;
    npc      = redirect ? target : pc_f_plus4;
  end

  // The fetch address is checked, not the target: a jr to a bad address is taken as-is
  // and shows up as a faulted instruction once it reaches D.
  always_comb begin
    misaligned   = (pc_f_q[1:0] != 2'b00);
    below_window = ({1'b0, pc_f_q} < WinFirst);
    above_window = ({1'b0, pc_f_q} > WinLast);
    fetch_fault  = misaligned | below_window | above_window;
  end

  always_comb begin
`ifdef IFU_DELAY_SLOT_EN
    // The delay-slot instruction always executes.
    squash = 1'b0;
`else
    // The word fetched alongside a redirect is on the wrong path.
    squash = redirect;
`endif
    if (squash) begin
      ins_load   = 32'h0000_0000;
      valid_load = 1'b0;
      fault_load = 1'b0;
    end else begin
      // A faulted fetch becomes a nop but stays valid so the fault can be reported.
      ins_load   = fetch_fault ? 32'h0000_0000 : ins_F;
      valid_load = 1'b1;
      fault_load = fetch_fault;
    end
  end

  // Reset overrides stall. A stall freezes everything: D keeps the same instruction, so a
  // redirect held back by the stall is evaluated again once the stall drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= PC_RESET;
      ins_d_q   <= 32'h0000_0000;
      pc_d_q    <= PC_RESET;
      pc8_d_q   <= PC_RESET + 32'd8;
      valid_d_q <= 1'b0;
      fault_d_q <= 1'b0;
    end else if (!stall) begin
      pc_f_q    <= npc;
      ins_d_q   <= ins_load;
      pc_d_q    <= pc_f_q;
      pc8_d_q   <= pc_f_plus8;
      valid_d_q <= valid_load;
      fault_d_q <= fault_load;
    end
  end

  assign pc_F          = pc_f_q;
  assign ins_D         = ins_d_q;
  assign pc_D          = pc_d_q;
  assign pc8_D         = pc8_d_q;
  assign valid_D       = valid_d_q;
  assign fetch_fault_D = fault_d_q;

endmodule

// File: doc/ifu_fetch_stage.md
Name: ifu_fetch_stage

Overview:
- Instruction-fetch stage for the pipelined MIPS core.
- Holds the fetch PC, drives it to the instruction memory, and takes back the fetched word. That word is latched into the IF/ID pipeline register.
- Next-PC selection (sequential, branch, j/jal, jr) is resolved from the D-stage instruction. The block also handles stall, redirect squash and fetch-address fault flagging.

Parameters:
- PC_RESET, 32'h0000_3000, fetch address after reset and base of the instruction memory window.
- IM_DEPTH_WORDS, 4096, instruction memory size in words; legal window is PC_RESET .. PC_RESET+4*IM_DEPTH_WORDS-4.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from the hazard unit: hold the PC and IF/ID contents.
- npc_sel  input  2  D-stage next-PC select: 00 PC+4, 01 branch, 10 j/jal, 11 jr.
- branch_taken  input  1  branch comparison result for the D-stage instruction.
- imm16_D  input  16  D-stage immediate (branch offset).
- instr_index_D  input  26  D-stage jump index.
- rs_val_D  input  32  forwarded rs value for jr.
- ins_F  input  32  instruction word returned by the instruction memory for pc_F (combinational read).
- pc_F  output  32  current fetch address, driven to the instruction memory.
- ins_D  output  32  IF/ID latched instruction.
- pc_D  output  32  IF/ID latched PC.
- pc8_D  output  32  pc_D+8, the link value for jal.
- valid_D  output  1  IF/ID holds a real instruction.
- fetch_fault_D  output  1  latched instruction came from a misaligned or out-of-window address.

Behaviour:
- Reset values, all applied synchronously on the first edge with reset=1 and overriding stall:
  - pc_F=PC_RESET, ins_D=0, pc_D=PC_RESET, pc8_D=PC_RESET+8.
  - valid_D=0, fetch_fault_D=0.
- Reset asserted mid-operation discards any pending redirect.
- Redirect condition: redirect = valid_D & ((npc_sel==01 & branch_taken) | npc_sel==10 | npc_sel==11).
  - npc_sel==01 with branch_taken=0 yields PC+4.
  - While valid_D=0, npc_sel is ignored.
- Targets, all arithmetic modulo 2^32:
  - branch: pc_D+4+(sign_ext(imm16_D)<<2).
  - j/jal: {pc_D_plus4[31:28], instr_index_D, 2'b00}, where pc_D_plus4 = pc_D+4.
  - jr: rs_val_D unmodified.
- Next PC: npc = redirect ? target : pc_F+4. Sequential fetch from 32'hFFFF_FFFC wraps to 0.
- Normal cycle (stall=0):
  - pc_F<=npc.
  - IF/ID <= {ins_F, pc_F, pc_F+8, valid=1, fault}.
- stall=1: pc_F and every IF/ID output hold their values.
  - Stall takes priority over redirect; the redirect is re-evaluated when stall drops, because D still holds the same instruction.
- Fault: fault = (pc_F[1:0]!=0) | pc_F<PC_RESET | pc_F>PC_RESET+4*IM_DEPTH_WORDS-4.
  - On a fault, ins_D latches 0 (nop) instead of ins_F, valid_D=1 and fetch_fault_D=1.
  - A jr to a bad address is taken without checking; the fault shows up one cycle later in D.
- Redirect latency: target appears on pc_F one cycle after the redirecting instruction is in D.
- Squash behaviour depends on the optional feature below.

Optional Feature:
- Macro: IFU_DELAY_SLOT_EN.
- Defined: MIPS delay-slot semantics. On redirect, the instruction at pc_F enters IF/ID normally (valid_D=1); no squash.
- Undefined: on a redirect with stall=0, the next IF/ID load is squashed: ins_D=0, valid_D=0, fetch_fault_D=0, while pc_D/pc8_D still latch pc_F / pc_F+8. Branch penalty is one bubble.

Test Plan:
- Reset, then 3 free cycles, ins_F echoed from a model memory -> pc_F = 3000,3004,3008,300C; first valid_D=1 holds pc_D=3000, pc8_D=3008.
- beq in D at pc_D=3008, imm16=FFFE, taken -> next pc_F=3004. With delay slot: ins_D = word@300C, valid_D=1. Without: valid_D=0, ins_D=0.
- j at pc_D=3010, instr_index=0000C40 -> pc_F=3100. jr with rs_val_D=3044 -> pc_F=3044. Branch with branch_taken=0 -> pc_F+4.
- stall=1 for 2 cycles while a taken branch sits in D -> pc_F and IF/ID frozen for both cycles; redirect to target occurs on the first cycle after stall=0.
- jr to 3002, and separately sequential fetch reaching 7000 (default params) -> fetch_fault_D=1, ins_D=0, valid_D=1 one cycle after the bad pc_F.
- reset asserted same cycle as a taken j with stall=1 -> next pc_F=3000, valid_D=0, fetch_fault_D=0.
